// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the wait-state counter width.
package data_mem_pkg;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dm_byte_array.sv
// Byte storage split into an even and an odd lane so a byte at addr and its
// neighbour at addr+1 can be read and written in the same cycle.
module dm_byte_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-2:0] clr_row,
  input  logic [AW-1:0] addr,
  input  logic          we_lo,
  input  logic          we_hi,
  input  logic [7:0]    wdata_lo,
  input  logic [7:0]    wdata_hi,
  output logic [7:0]    rdata_lo,
  output logic [7:0]    rdata_hi
);

  localparam int ROWS = DEPTH_BYTES / 2;

  logic [AW-1:0] addr_hi;
  logic [7:0]    rd_lo_lane [2];
  logic [7:0]    rd_hi_lane [2];

  // Wraps at the top; such accesses are rejected by the range check anyway.
  assign addr_hi = addr + AW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [ROWS];
      logic       wr_lo;
      logic       wr_hi;

      assign wr_lo = we_lo && (addr[0] == 1'(gi));
      assign wr_hi = we_hi && (addr_hi[0] == 1'(gi));

      // addr and addr+1 always land in different lanes, so at most one write
      // path is active per lane.
      always_ff @(posedge clk) begin
        if (clr) begin
          mem[clr_row] <= 8'h00;
        end else if (wr_lo) begin
          mem[addr[AW-1:1]] <= wdata_lo;
        end else if (wr_hi) begin
          mem[addr_hi[AW-1:1]] <= wdata_hi;
        end
      end

      assign rd_lo_lane[gi] = mem[addr[AW-1:1]];
      assign rd_hi_lane[gi] = mem[addr_hi[AW-1:1]];
    end
  endgenerate

  assign rdata_lo = rd_lo_lane[addr[0]];
  assign rdata_hi = rd_hi_lane[addr_hi[0]];

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory with valid/ready requests,
// programmable wait states, a one-cycle response pulse and a clear sweep.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [AW-2:0] LAST_ROW = (AW-1)'(DEPTH_BYTES / 2 - 1);

  generate
    if (DATA_W != 16) begin : g_bad_width
      $error("data_mem_ctrl: DATA_W must be 16");
    end
    if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
      $error("data_mem_ctrl: DEPTH_BYTES must be a power of two >= 4");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_mem_ctrl: WAIT_CYCLES must be 0..15");
    end
  endgenerate

  state_t              state_reg,   state_next;
  logic [CNT_W-1:0]    cnt_reg,     cnt_next;
  logic [AW-2:0]       clr_idx_reg, clr_idx_next;
  logic [ADDR_W-1:0]   addr_reg,    addr_next;
  logic                we_reg,      we_next;
  logic                size_reg,    size_next;
  logic [DATA_W-1:0]   wdata_reg,   wdata_next;
  logic [DATA_W-1:0]   rdata_reg,   rdata_next;
  logic                err_reg,     err_next;

  logic                clr;
  logic                do_access;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_we;
  logic                acc_size;
  logic [DATA_W-1:0]   acc_wdata;
  logic [ADDR_W:0]     acc_last;
  logic                acc_err;
  logic                mem_we_lo;
  logic                mem_we_hi;
  logic [7:0]          mem_rd_lo;
  logic [7:0]          mem_rd_hi;

  // With no wait states the access happens on the accepting edge, so it must
  // use the live request rather than the latched copy.
  assign acc_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign acc_we    = (state_reg == IDLE) ? req_we    : we_reg;
  assign acc_size  = (state_reg == IDLE) ? req_size  : size_reg;
  assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

  // Full-width range check so high address bits never alias into the array.
  assign acc_last = {1'b0, acc_addr} + (ADDR_W+1)'(acc_size);
  assign acc_err  = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                    (acc_last >= (ADDR_W+1)'(DEPTH_BYTES));

  assign mem_we_lo = do_access && acc_we && !acc_err;
  assign mem_we_hi = mem_we_lo && (acc_size == SZ_HALF);

  dm_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_array (
    .clk      (clk),
    .clr      (clr),
    .clr_row  (clr_idx_reg),
    .addr     (acc_addr[AW-1:0]),
    .we_lo    (mem_we_lo),
    .we_hi    (mem_we_hi),
    .wdata_lo (acc_wdata[7:0]),
    .wdata_hi (acc_wdata[15:8]),
    .rdata_lo (mem_rd_lo),
    .rdata_hi (mem_rd_hi)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= INIT;
      cnt_reg     <= '0;
      clr_idx_reg <= '0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      size_reg    <= SZ_BYTE;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      clr_idx_reg <= clr_idx_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      size_reg    <= size_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    clr_idx_next = clr_idx_reg;
    addr_next    = addr_reg;
    we_next      = we_reg;
    size_next    = size_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    req_ready    = 1'b0;
    clr          = 1'b0;
    do_access    = 1'b0;

    case (state_reg)
      INIT: begin
        clr          = 1'b1;
        clr_idx_next = clr_idx_reg + 1'b1;
        if (clr_idx_reg == LAST_ROW) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_next  = req_addr;
          we_next    = req_we;
          size_next  = req_size;
          wdata_next = req_wdata;
          if (WAIT_CYCLES == 0) begin
            do_access  = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_W'(WAIT_CYCLES);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          do_access  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = INIT;
      end
    endcase

    // Writes and rejected accesses return zero data.
    if (do_access) begin
      err_next = acc_err;
      if (acc_err || acc_we) begin
        rdata_next = '0;
      end else if (acc_size == SZ_HALF) begin
        rdata_next = DATA_W'({mem_rd_hi, mem_rd_lo});
      end else begin
        rdata_next = DATA_W'({8'h00, mem_rd_lo});
      end
    end
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances with 0, 2 and 3 wait
// states share one clock; a monitor checks every response pulse.
module tb_data_mem_ctrl;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
    logic        c;
    logic [1:0]  inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic        req_size  [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q [$];
  exp_t mon_e;

  always #5 clk = ~clk;

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int W = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
      data_mem_ctrl #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .DEPTH_BYTES (64),
        .WAIT_CYCLES (W)
      ) dut (
        .clk       (clk),
        .reset     (reset[gi]),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_size  (req_size[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp inst=%0d act=rsp_valid=1 exp=no response", i);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_inst", 32'(i), 32'(mon_e.inst));
          chk("rsp_err", 32'(rsp_err[i]), 32'(mon_e.e));
          if (mon_e.c) chk("rsp_rdata", 32'(rsp_rdata[i]), 32'(mon_e.d));
          $display("rsp inst=%0d rdata=%04h err=%0d", i, rsp_rdata[i], rsp_err[i]);
        end
      end
    end
  end

  // One request: wait for ready, push expectation, then check the
  // ready/valid timeline up to the return to IDLE.
  task automatic do_req(input int i, input logic we, input logic sz,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_d, input logic exp_e,
                        input logic chk_d, input logic hold, input string nm);
    int  w;
    bit  got;
    w   = wait_of(i);
    got = 1'b0;
    @(negedge clk);
    req_we[i]    = we;
    req_size[i]  = sz;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (req_ready[i] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_accept act=req_ready never high exp=accepted", nm);
      req_valid[i] = 1'b0;
      return;
    end
    sb_q.push_back('{d: exp_d, e: exp_e, c: chk_d, inst: 2'(i)});
    $display("req inst=%0d %s we=%0d size=%0d addr=%04h wdata=%04h", i, nm, we, sz, addr, wd);
    @(posedge clk);
    #1;
    if (!hold) req_valid[i] = 1'b0;
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      chk({nm, "_rsp_valid"}, 32'(rsp_valid[i]), 32'(k == w));
      chk({nm, "_busy_ready"}, 32'(req_ready[i]), 32'd0);
    end
    @(negedge clk);
    chk({nm, "_idle_valid"}, 32'(rsp_valid[i]), 32'd0);
    chk({nm, "_idle_ready"}, 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_ready", 32'(req_ready[i]), 32'd0);
    chk("rst_valid", 32'(rsp_valid[i]), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata[i]), 32'd0);
    chk("rst_err",   32'(rsp_err[i]),   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset[i]     = 1'b0;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_size[i]  = 1'b0;
      req_addr[i]  = 16'h0;
      req_wdata[i] = 16'h0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset_vals(i);
    for (int i = 0; i < 3; i++) reset[i] = 1'b1;

    // Clear sweep: 32 cycles with req_ready low, then ready.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("init_ready", 32'(req_ready[i]), 32'(k == 32));
    end

    // Zero wait states.
    do_req(0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 1, 0, "t1_hr10");
    do_req(0, 1, 1, 16'h0004, 16'hBEEF, 16'h0000, 0, 0, 0, "t2_hw04");
    do_req(0, 0, 0, 16'h0004, 16'h0000, 16'h00EF, 0, 1, 0, "t2_br04");
    do_req(0, 0, 0, 16'h0005, 16'h0000, 16'h00BE, 0, 1, 0, "t2_br05");
    do_req(0, 1, 0, 16'h0005, 16'hA512, 16'h0000, 0, 0, 0, "t3_bw05");
    do_req(0, 0, 1, 16'h0004, 16'h0000, 16'h12EF, 0, 1, 0, "t3_hr04");
    do_req(0, 1, 1, 16'h0002, 16'h7788, 16'h0000, 0, 0, 0, "t4_hw02");
    do_req(0, 1, 1, 16'h0003, 16'h1111, 16'h0000, 1, 1, 0, "t4_hw03_mis");
    do_req(0, 1, 1, 16'h0040, 16'h2222, 16'h0000, 1, 1, 0, "t4_hw40_oor");
    do_req(0, 0, 1, 16'h0002, 16'h0000, 16'h7788, 0, 1, 0, "t4_hr02");
    do_req(0, 0, 1, 16'h0004, 16'h0000, 16'h12EF, 0, 1, 0, "t4_hr04");
    do_req(0, 1, 0, 16'h003F, 16'h00C3, 16'h0000, 0, 0, 0, "bw3f");
    do_req(0, 0, 1, 16'h003E, 16'h0000, 16'hC300, 0, 1, 0, "hr3e");
    do_req(0, 0, 1, 16'h003F, 16'h0000, 16'h0000, 1, 1, 0, "hr3f_mis");
    do_req(0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 1, 1, 0, "br40_oor");
    do_req(0, 0, 1, 16'hFFFE, 16'h0000, 16'h0000, 1, 1, 0, "hrfffe_oor");
    do_req(0, 0, 0, 16'h1004, 16'h0000, 16'h0000, 1, 1, 0, "br1004_alias");

    // Two wait states, held req_valid must not be re-accepted.
    do_req(1, 1, 1, 16'h000A, 16'hCAFE, 16'h0000, 0, 0, 0, "t5_hw0a");
    do_req(1, 0, 1, 16'h000A, 16'h0000, 16'hCAFE, 0, 1, 1, "t5_hr0a_hold");
    do_req(1, 0, 0, 16'h000B, 16'h0000, 16'h00CA, 0, 1, 0, "t5_br0b");

    // Three wait states, reset lands while a write is pending.
    do_req(2, 1, 1, 16'h0008, 16'h5A5A, 16'h0000, 0, 0, 0, "t6_hw08");
    do_req(2, 0, 1, 16'h0008, 16'h0000, 16'h5A5A, 0, 1, 0, "t6_hr08");
    @(negedge clk);
    req_we[2]    = 1'b1;
    req_size[2]  = 1'b1;
    req_addr[2]  = 16'h0008;
    req_wdata[2] = 16'h1234;
    req_valid[2] = 1'b1;
    chk("t6_pre_ready", 32'(req_ready[2]), 32'd1);
    $display("req inst=2 t6_hw08_abort we=1 size=1 addr=0008 wdata=1234");
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    reset[2] = 1'b0;
    #1;
    chk_reset_vals(2);
    @(negedge clk);
    reset[2] = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("t6_init_ready", 32'(req_ready[2]), 32'(k == 32));
    end
    do_req(2, 0, 1, 16'h0008, 16'h0000, 16'h0000, 0, 1, 0, "t6_hr08_after");

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressable, little-endian data memory for the 16-bit CPU datapath.
- Replaces the fixed 64-byte combinational-read memory with the following features:
  - valid/ready request handshake;
  - byte and halfword accesses;
  - configurable wait states;
  - a registered single-pulse response;
  - error reporting;
  - a hardware clear sweep after reset.
- Sits between the execute/memory stage and the memory-stage pipeline register.

Parameters:
- DATA_W, 16, data width in bits. Fixed at 16 in this generation and checked by an elaboration assertion.
- ADDR_W, 16, request address width.
- DEPTH_BYTES, 64, storage size in bytes. Must be a power of two and at least 4.
- WAIT_CYCLES, 0, extra cycles between request acceptance and response. Range is 0 to 15.

Ports:
- clk  in  1  single clock. All state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_size  in  1  0 = byte, 1 = halfword.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data. A byte write uses [7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data. Byte reads are zero-extended.
- rsp_err  out  1  access rejected.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=INIT, clear index=0;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - any latched request is discarded.
  - Reset mid-WAIT: the pending write never commits.
- INIT:
  - each cycle zero two bytes at index*2, then increment the index;
  - after DEPTH_BYTES/2 cycles go to IDLE;
  - req_ready stays 0 throughout INIT.
- IDLE:
  - req_ready=1;
  - a request is accepted on an edge where req_valid & req_ready; addr, we, size and wdata are latched at that edge.
- Acceptance at edge N:
  - WAIT_CYCLES=0: go to RESP at edge N and perform the access at edge N.
  - WAIT_CYCLES=W>0: go to WAIT with cnt=W, decrement each edge, and enter RESP when cnt reaches 1 (edge N+W). Perform the access at edge N+W.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err valid alongside;
  - next edge: IDLE with rsp_valid=0.
  - rsp_rdata and rsp_err hold their values until the next response or reset.
- req_ready is 0 in WAIT and RESP. Maximum throughput is one access per W+2 cycles.
- Error check, on the latched request:
  - halfword with addr[0]=1 is an error (misaligned);
  - addr+size ≥ DEPTH_BYTES is an error (out of range);
  - on error: no storage change, rsp_err=1, rsp_rdata=0.
- Halfword access:
  - write sets mem[a]=wdata[7:0] and mem[a+1]=wdata[15:8];
  - read returns {mem[a+1], mem[a]}.
- Byte access:
  - write modifies only mem[a];
  - read returns {8'h00, mem[a]}.
- Read data reflects all previously completed writes; there is no internal forwarding hazard because accesses are serialised.
- Upper address bits above log2(DEPTH_BYTES) are checked for range only and never aliased.
- The block performs no file I/O.

Decomposition:
- Package data_mem_pkg holds:
  - size encodings SZ_BYTE=0 and SZ_HALF=1;
  - the state enum INIT/IDLE/WAIT/RESP;
  - the WAIT counter width constant (4).
- Sub-module dm_byte_array holds the storage. It has:
  - two byte lanes, each with a per-lane write enable;
  - a combinational read of addr and addr+1;
  - a clear port driven during INIT.
- data_mem_ctrl keeps the FSM, wait counter, error check and output registers.

Test Plan:
1. Reset, DEPTH_BYTES=64:
   - req_ready stays 0 for 32 cycles after reset deasserts, then rises;
   - a halfword read of 0x0010 returns rsp_rdata=0x0000 and rsp_err=0.
2. Halfword write 0xBEEF to 0x0004, then byte reads of 0x0004 and 0x0005:
   - the reads return 0x00EF and 0x00BE;
   - with WAIT_CYCLES=0, rsp_valid pulses the cycle after each acceptance.
3. Byte write 0xA512 to 0x0005, then a halfword read of 0x0004:
   - the read returns 0x12EF, showing only byte 5 changed.
4. Halfword write to 0x0003, then a halfword write to 0x0040:
   - both give rsp_err=1 and rsp_rdata=0;
   - a subsequent halfword read of 0x0002 is unchanged.
5. WAIT_CYCLES=2, read accepted at edge N:
   - rsp_valid is high only between edges N+2 and N+3;
   - req_ready is 0 from N to N+3, and a held req_valid is not accepted again until IDLE.
6. WAIT_CYCLES=3, halfword write 0x1234 to 0x0008, with reset pulsed low one cycle after acceptance:
   - outputs go to reset values immediately and INIT reruns;
   - a later read of 0x0008 returns 0x0000.
